// File: rtl/exec_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer for the 9-bit core.
// Optional retired-instruction counter enabled by `define EXEC_SEQ_PERF_CNT_EN.
module exec_sequencer #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            imem_req,
  input  logic            imem_valid,
  input  logic [8:0]      imem_instr,
  output logic [8:0]      ir,
  output logic [PC_W-1:0] pc,
  output logic            alu_op,
  output logic            branch,
  input  logic            alu_zero,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
  output logic            reg_write,
  output logic            busy,
  output logic            done,
  output logic [15:0]     retired_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [8:0]      ir_q, ir_d;
  logic            retire;

  logic            cls_mem, cls_br, is_halt, is_store;
  logic [PC_W-1:0] br_off;

  assign cls_mem  = (ir_q[8:7] == 2'b01);
  assign cls_br   = (ir_q[8:7] == 2'b10);
  assign is_halt  = (ir_q == 9'h1FF);
  assign is_store = ir_q[6];
  assign br_off   = PC_W'($signed(ir_q[5:0]));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    retire  = 1'b0;
    case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH:  if (imem_valid) begin
                  ir_d    = imem_instr;
                  state_d = S_DECODE;
                end
      S_DECODE: if (is_halt) begin
                  state_d = S_HALT;
                  retire  = 1'b1;
                end else begin
                  state_d = S_EXEC;
                end
      S_EXEC:   if (cls_br) begin
                  // branch-not-equal: taken when the compare is non-zero
                  pc_d    = alu_zero ? pc_q + PC_W'(1) : pc_q + br_off;
                  state_d = S_FETCH;
                  retire  = 1'b1;
                end else if (cls_mem) begin
                  state_d = S_MEM;
                end else begin
                  state_d = S_WB;
                end
      S_MEM:    if (dmem_ack) begin
                  if (is_store) begin
                    pc_d    = pc_q + PC_W'(1);
                    state_d = S_FETCH;
                    retire  = 1'b1;
                  end else begin
                    state_d = S_WB;
                  end
                end
      S_WB:     begin
                  pc_d    = pc_q + PC_W'(1);
                  state_d = S_FETCH;
                  retire  = 1'b1;
                end
      S_HALT:   if (start) begin
                  pc_d    = RESET_PC;
                  state_d = S_FETCH;
                end
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Moore outputs: pure decodes of registered state
  assign imem_req  = (state_q == S_FETCH);
  assign alu_op    = (state_q == S_EXEC);
  assign branch    = (state_q == S_EXEC) && cls_br;
  assign dmem_req  = (state_q == S_MEM);
  assign dmem_we   = (state_q == S_MEM) && is_store;
  assign reg_write = (state_q == S_WB);
  assign done      = (state_q == S_HALT);
  assign busy      = (state_q != S_IDLE) && (state_q != S_HALT);
  assign pc        = pc_q;
  assign ir        = ir_q;

`ifdef EXEC_SEQ_PERF_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (retire && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign retired_cnt = cnt_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
  assign retired_cnt   = '0;
`endif

endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench for exec_sequencer: directed table, reset/halt sequences,
// and randomized instructions checked against a per-instruction schedule model.
module tb_exec_sequencer;
  localparam int PC_W = 8;
  localparam logic [PC_W-1:0] RESET_PC = '0;

  logic        clk = 0, reset, start, imem_valid, alu_zero, dmem_ack;
  logic [8:0]  imem_instr, ir;
  logic [PC_W-1:0] pc;
  logic        imem_req, alu_op, branch, dmem_req, dmem_we, reg_write, busy, done;
  logic [15:0] retired_cnt;

  exec_sequencer #(.PC_W(PC_W), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_req(imem_req), .imem_valid(imem_valid), .imem_instr(imem_instr),
    .ir(ir), .pc(pc), .alu_op(alu_op), .branch(branch), .alu_zero(alu_zero),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .reg_write(reg_write), .busy(busy), .done(done), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  // {imem_req, alu_op, branch, dmem_req, dmem_we, reg_write, busy, done}
  localparam logic [7:0] O_IDLE  = 8'b0000_0000;
  localparam logic [7:0] O_FETCH = 8'b1000_0010;
  localparam logic [7:0] O_DEC   = 8'b0000_0010;
  localparam logic [7:0] O_EXEC  = 8'b0100_0010;
  localparam logic [7:0] O_BR    = 8'b0110_0010;
  localparam logic [7:0] O_LD    = 8'b0001_0010;
  localparam logic [7:0] O_ST    = 8'b0001_1010;
  localparam logic [7:0] O_WB    = 8'b0000_0110;
  localparam logic [7:0] O_HALT  = 8'b0000_0001;

  typedef struct {
    logic [7:0] outs;
    logic iv, da, is_fetch, is_mem, is_exec, chk_ir;
  } step_t;

  typedef struct {
    logic [8:0] instr; int iw; int dw; logic az; logic [PC_W-1:0] exp_pc;
  } vec_t;

  int n_chk = 0, n_fail = 0;
  int mpc, mcnt;

  function automatic logic [7:0] outs_now();
    return {imem_req, alu_op, branch, dmem_req, dmem_we, reg_write, busy, done};
  endfunction

  function automatic int exp_cnt();
`ifdef EXEC_SEQ_PERF_CNT_EN
    return mcnt;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic step_t mk(input logic [7:0] o, input logic iv, input logic da,
                               input logic f, input logic m, input logic e, input logic ci);
    step_t s;
    s.outs = o; s.iv = iv; s.da = da; s.is_fetch = f; s.is_mem = m; s.is_exec = e; s.chk_ir = ci;
    return s;
  endfunction

  // Entered at the negedge of the instruction's first FETCH cycle; returns at the
  // negedge of the following instruction's FETCH (or of HALT).
  task automatic run_instr(input logic [8:0] instr, input int iw, input int dw, input logic az);
    step_t q[$];
    int off;
    logic halt;
    halt = (instr == 9'h1FF);
    for (int i = 0; i <= iw; i++) q.push_back(mk(O_FETCH, i == iw, 0, 1, 0, 0, 0));
    q.push_back(mk(O_DEC, 0, 0, 0, 0, 0, 1));
    if (!halt) begin
      q.push_back(mk(instr[8:7] == 2'b10 ? O_BR : O_EXEC, 0, 0, 0, 0, 1, 1));
      if (instr[8:7] == 2'b01) begin
        for (int j = 0; j <= dw; j++) q.push_back(mk(instr[6] ? O_ST : O_LD, 0, j == dw, 0, 1, 0, 1));
        if (!instr[6]) q.push_back(mk(O_WB, 0, 0, 0, 0, 0, 1));
      end else if (instr[8:7] != 2'b10) begin
        q.push_back(mk(O_WB, 0, 0, 0, 0, 0, 1));
      end
    end
    foreach (q[k]) begin
      chk("outs", outs_now(), q[k].outs);
      chk("pc", pc, mpc);
      if (q[k].chk_ir) chk("ir", ir, instr);
      start      = 1'($urandom);
      imem_valid = q[k].is_fetch ? q[k].iv : 1'($urandom);
      imem_instr = (q[k].is_fetch && q[k].iv) ? instr : 9'($urandom);
      dmem_ack   = q[k].is_mem ? q[k].da : 1'($urandom);
      alu_zero   = q[k].is_exec ? az : 1'($urandom);
      @(negedge clk);
    end
    start = 0; imem_valid = 0; dmem_ack = 0;
    if (halt) begin
      chk("halt_outs", outs_now(), O_HALT);
    end else if (instr[8:7] == 2'b10 && !az) begin
      off = instr[5] ? int'(instr[5:0]) - 64 : int'(instr[5:0]);
      mpc = (mpc + off) & ((1 << PC_W) - 1);
    end else begin
      mpc = (mpc + 1) & ((1 << PC_W) - 1);
    end
    if (mcnt < 65535) mcnt++;
    chk("pc_after", pc, mpc);
    chk("retired_cnt", retired_cnt, exp_cnt());
  endtask

  task automatic restart();
    start = 1; imem_valid = 0; dmem_ack = 0;
    @(negedge clk);
    start = 0;
    mpc = RESET_PC;
    chk("restart_outs", outs_now(), O_FETCH);
    chk("restart_pc", pc, RESET_PC);
  endtask

  task automatic do_reset();
    reset = 1; start = 0; imem_valid = 0; dmem_ack = 0;
    @(negedge clk);
    reset = 0;
    mpc = RESET_PC; mcnt = 0;
    chk("rst_outs", outs_now(), O_IDLE);
    chk("rst_pc", pc, RESET_PC);
    chk("rst_ir", ir, 0);
    chk("rst_cnt", retired_cnt, 0);
  endtask

  initial begin
    vec_t tbl[14];
    logic [8:0] ri;
    tbl[0]  = '{9'h010, 0, 0, 0, 8'h01};
    tbl[1]  = '{9'h180, 0, 0, 0, 8'h02};
    tbl[2]  = '{9'h011, 2, 0, 0, 8'h03};
    tbl[3]  = '{9'h0C0, 0, 0, 0, 8'h04};
    tbl[4]  = '{9'h012, 0, 0, 0, 8'h05};
    tbl[5]  = '{9'h13E, 0, 0, 0, 8'h03};
    tbl[6]  = '{9'h014, 0, 0, 0, 8'h04};
    tbl[7]  = '{9'h015, 0, 0, 0, 8'h05};
    tbl[8]  = '{9'h13E, 0, 0, 1, 8'h06};
    tbl[9]  = '{9'h080, 0, 3, 0, 8'h07};
    tbl[10] = '{9'h1FF, 0, 0, 0, 8'h07};
    tbl[11] = '{9'h13E, 0, 0, 0, 8'hFE};
    tbl[12] = '{9'h010, 1, 0, 0, 8'hFF};
    tbl[13] = '{9'h010, 0, 0, 0, 8'h00};

    reset = 1; start = 0; imem_valid = 0; imem_instr = 0; alu_zero = 0; dmem_ack = 0;
    @(negedge clk);
    do_reset();

    start = 1;
    @(negedge clk);
    start = 0;
    for (int k = 0; k < 14; k++) begin
      run_instr(tbl[k].instr, tbl[k].iw, tbl[k].dw, tbl[k].az);
      chk("tbl_pc", pc, tbl[k].exp_pc);
      if (tbl[k].instr == 9'h1FF) begin
        @(negedge clk);
        chk("halt_hold_pc", pc, tbl[k].exp_pc);
        chk("halt_hold_outs", outs_now(), O_HALT);
        restart();
      end
    end

    // reset while a load is waiting in MEM, then a stray ack
    imem_valid = 1; imem_instr = 9'h080;
    @(negedge clk); imem_valid = 0;
    @(negedge clk);
    @(negedge clk);
    chk("mem_req_before_rst", outs_now(), O_LD);
    reset = 1;
    @(negedge clk);
    reset = 0; dmem_ack = 1;
    mpc = RESET_PC; mcnt = 0;
    chk("midrst_outs", outs_now(), O_IDLE);
    chk("midrst_pc", pc, RESET_PC);
    chk("midrst_ir", ir, 0);
    chk("midrst_cnt", retired_cnt, 0);
    @(negedge clk);
    dmem_ack = 0;
    chk("stray_ack_outs", outs_now(), O_IDLE);

    // three ALU instructions plus HALT
    start = 1;
    @(negedge clk);
    start = 0;
    run_instr(9'h001, 0, 0, 0);
    run_instr(9'h002, 0, 0, 0);
    run_instr(9'h003, 0, 0, 0);
    run_instr(9'h1FF, 0, 0, 0);
`ifdef EXEC_SEQ_PERF_CNT_EN
    chk("cnt_four", retired_cnt, 16'd4);
`else
    chk("cnt_tied", retired_cnt, 16'd0);
`endif
    chk("halt_pc3", pc, 8'h03);
    restart();

    for (int n = 0; n < 200; n++) begin
      ri = 9'($urandom);
      if ($urandom_range(0, 39) == 0) ri = 9'h1FF;
      run_instr(ri, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom));
      if (ri == 9'h1FF) restart();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
